// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: filters SCL/SDA, detects START/RESTART/STOP, decodes bytes into a record FIFO.
// Optional SCL-low timeout is enabled by defining I2C_MON_TIMEOUT_EN.
module i2c_bus_monitor #(
    parameter int FILT_LEN    = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          scl_i,
    input  logic                          sda_i,
    output logic                          start_o,
    output logic                          restart_o,
    output logic                          stop_o,
    output logic                          busy_o,
    output logic                          proto_err_o,
    output logic                          rd_valid_o,
    output logic [10:0]                   rd_data_o,
    input  logic                          rd_en_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          ovf_o,
    input  logic                          ovf_clr_i,
    output logic                          timeout_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILT_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_BITS, S_ACK} state_t;

    // Index 0 carries SCL, index 1 carries SDA.
    logic [1:0]    r_sync1, r_sync2, r_filt, r_filt_d;
    logic [FW-1:0] r_stab [2];

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [3:0]    r_bits_done, w_bits_done_nxt;
    logic [7:0]    r_byte, w_byte_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_start, r_restart, r_stop, r_perr;
    logic          w_start_nxt, w_restart_nxt, w_stop_nxt, w_perr_nxt;
    logic          w_push;
    logic [10:0]   w_push_data;
    logic          w_to_hit;

    logic [10:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          w_pop, w_full, w_wr, w_ovf_set;

    logic w_scl_f, w_sda_f, w_scl_rise, w_sda_fall, w_sda_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 2'b11;
            r_sync2  <= 2'b11;
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
            for (int i = 0; i < 2; i++) r_stab[i] <= '0;
        end else begin
            r_sync1  <= {sda_i, scl_i};
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_stab[i] <= '0;
                end else if (r_stab[i] == FW'(FILT_LEN - 1)) begin
                    r_stab[i] <= '0;
                    r_filt[i] <= r_sync2[i];
                end else begin
                    r_stab[i] <= r_stab[i] + FW'(1);
                end
            end
        end
    end

    assign w_scl_f    = r_filt[0];
    assign w_sda_f    = r_filt[1];
    assign w_scl_rise = r_filt[0] & ~r_filt_d[0];
    assign w_sda_fall = ~r_filt[1] & r_filt_d[1];
    assign w_sda_rise = r_filt[1] & ~r_filt_d[1];

`ifdef I2C_MON_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;

    assign w_to_hit = r_busy && !w_scl_f && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_hit;
            if (!r_busy || w_scl_f || w_to_hit) r_to_cnt <= '0;
            else                                r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_to_hit  = (TIMEOUT_CYC < 0);
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_bits_done <= '0;
            r_byte      <= '0;
            r_busy      <= 1'b0;
            r_start     <= 1'b0;
            r_restart   <= 1'b0;
            r_stop      <= 1'b0;
            r_perr      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_bits_done <= w_bits_done_nxt;
            r_byte      <= w_byte_nxt;
            r_busy      <= w_busy_nxt;
            r_start     <= w_start_nxt;
            r_restart   <= w_restart_nxt;
            r_stop      <= w_stop_nxt;
            r_perr      <= w_perr_nxt;
        end
    end

    // The SCL rise that precedes every STOP/RESTART is not a data bit, so the
    // partial-byte check uses the bit count held before the latest SCL rise.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_bits_done_nxt = r_bits_done;
        w_byte_nxt      = r_byte;
        w_busy_nxt      = r_busy;
        w_start_nxt     = 1'b0;
        w_restart_nxt   = 1'b0;
        w_stop_nxt      = 1'b0;
        w_perr_nxt      = 1'b0;
        w_push          = 1'b0;
        w_push_data     = '0;
        if (w_scl_f && w_sda_fall) begin
            w_start_nxt     = !r_busy;
            w_restart_nxt   = r_busy;
            w_perr_nxt      = (r_bits_done != 4'd0);
            w_busy_nxt      = 1'b1;
            w_bit_cnt_nxt   = '0;
            w_bits_done_nxt = '0;
            w_state_nxt     = S_BITS;
            w_push          = 1'b1;
            w_push_data     = {(r_busy ? 2'b10 : 2'b01), 9'd0};
        end else if (w_scl_f && w_sda_rise) begin
            w_stop_nxt      = 1'b1;
            w_perr_nxt      = (r_bits_done != 4'd0);
            w_busy_nxt      = 1'b0;
            w_bit_cnt_nxt   = '0;
            w_bits_done_nxt = '0;
            w_state_nxt     = S_IDLE;
            w_push          = 1'b1;
            w_push_data     = {2'b11, 9'd0};
        end else if (w_to_hit) begin
            w_busy_nxt      = 1'b0;
            w_bit_cnt_nxt   = '0;
            w_bits_done_nxt = '0;
            w_state_nxt     = S_IDLE;
        end else if (w_scl_rise) begin
            w_bits_done_nxt = r_bit_cnt;
            case (r_state)
                S_BITS: begin
                    w_byte_nxt    = {r_byte[6:0], w_sda_f};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) w_state_nxt = S_ACK;
                end
                S_ACK: begin
                    w_push        = 1'b1;
                    w_push_data   = {2'b00, r_byte, w_sda_f};
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = S_BITS;
                end
                default: ;
            endcase
        end
    end

    assign w_pop     = rd_en_i && (r_count != '0);
    assign w_full    = (r_count == (AW + 1)'(FIFO_DEPTH));
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (ovf_clr_i) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= w_push_data;
    end

    assign start_o     = r_start;
    assign restart_o   = r_restart;
    assign stop_o      = r_stop;
    assign busy_o      = r_busy;
    assign proto_err_o = r_perr;
    assign rd_valid_o  = (r_count != '0);
    assign rd_data_o   = rd_valid_o ? r_mem[r_rptr] : 11'd0;
    assign count_o     = r_count;
    assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Randomized bench for i2c_bus_monitor: drives I2C bus transactions and checks records and
// pulses against a transaction-level model. Honours I2C_MON_TIMEOUT_EN when defined.
module tb_i2c_bus_monitor;

    localparam int FILT_LEN    = 4;
    localparam int FIFO_DEPTH  = 8;
    localparam int TIMEOUT_CYC = 100;
    localparam int Q           = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclIn = 1'b1;
    logic        sdaIn = 1'b1;
    logic        rdEn = 1'b0;
    logic        ovfClr = 1'b0;
    logic        startO, restartO, stopO, busyO, protoErrO, rdValidO, ovfO, timeoutO;
    logic [10:0] rdDataO;
    logic [3:0]  countO;

    i2c_bus_monitor #(
        .FILT_LEN(FILT_LEN), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .scl_i(sclIn), .sda_i(sdaIn),
        .start_o(startO), .restart_o(restartO), .stop_o(stopO), .busy_o(busyO),
        .proto_err_o(protoErrO), .rd_valid_o(rdValidO), .rd_data_o(rdDataO),
        .rd_en_i(rdEn), .count_o(countO), .ovf_o(ovfO), .ovf_clr_i(ovfClr),
        .timeout_o(timeoutO)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Transaction-level model: expected records, bus state and pulse tallies.
    logic [10:0] expQ[$];
    bit mBusy = 0;
    bit mPartial = 0;
    bit expOvf = 0;
    int expStart = 0, expRestart = 0, expStop = 0, expPerr = 0;
    int obsStart = 0, obsRestart = 0, obsStop = 0, obsPerr = 0, obsTimeout = 0, perrStray = 0;

    always @(negedge clk) begin
        if (startO)    obsStart++;
        if (restartO)  obsRestart++;
        if (stopO)     obsStop++;
        if (protoErrO) obsPerr++;
        if (timeoutO)  obsTimeout++;
        if (protoErrO && !(startO || restartO || stopO)) perrStray++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitQ();
        repeat (Q) @(negedge clk);
    endtask

    task automatic driveBit(input logic b);
        sdaIn = b;
        waitQ();
        sclIn = 1'b1;
        waitQ();
        waitQ();
        sclIn = 1'b0;
        waitQ();
    endtask

    task automatic modelPush(input logic [10:0] rec);
        if (expQ.size() < FIFO_DEPTH) expQ.push_back(rec);
        else expOvf = 1;
    endtask

    // op 0: START/RESTART, 1: full byte + ACK slot, 2: partial byte, 3: STOP
    task automatic applyStimulus(input int op, input logic [7:0] data, input logic ack, input int nbits);
        case (op)
            0: begin
                if (mPartial) expPerr++;
                if (mBusy) begin expRestart++; modelPush(11'h400); end
                else begin expStart++; modelPush(11'h200); end
                mBusy = 1; mPartial = 0;
                sdaIn = 1'b1; waitQ(); sclIn = 1'b1; waitQ();
                sdaIn = 1'b0; waitQ(); sclIn = 1'b0; waitQ();
            end
            1: begin
                modelPush({2'b00, data, ack});
                for (int i = 7; i >= 0; i--) driveBit(data[i]);
                driveBit(ack);
            end
            2: begin
                mPartial = 1;
                for (int i = 0; i < nbits; i++) driveBit(data[7-i]);
            end
            default: begin
                if (mPartial) expPerr++;
                expStop++; modelPush(11'h600);
                mBusy = 0; mPartial = 0;
                sdaIn = 1'b0; waitQ(); sclIn = 1'b1; waitQ();
                sdaIn = 1'b1; waitQ();
            end
        endcase
    endtask

    task automatic drainFifo();
        int n;
        n = expQ.size();
        checkOutput("count", countO, n);
        checkOutput("ovf", ovfO, expOvf);
        for (int i = 0; i < n; i++) begin
            checkOutput("rdValid", rdValidO, 1);
            checkOutput("record", rdDataO, expQ.pop_front());
            rdEn = 1'b1;
            @(negedge clk);
            rdEn = 1'b0;
        end
        checkOutput("fifoEmpty", rdValidO, 0);
    endtask

    task automatic checkPulses();
        checkOutput("startPulses", obsStart, expStart);
        checkOutput("restartPulses", obsRestart, expRestart);
        checkOutput("stopPulses", obsStop, expStop);
        checkOutput("protoErrPulses", obsPerr, expPerr);
    endtask

    function automatic logic [31:0] allOutputs();
        return {startO, restartO, stopO, busyO, protoErrO, rdValidO, ovfO, timeoutO, countO, rdDataO};
    endfunction

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int op;
        int r;
        repeat (4) @(negedge clk);
        checkOutput("resetOutputs", allOutputs(), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Two writes, both ACKed.
        applyStimulus(0, 8'h00, 1'b0, 0);
        checkOutput("busyAfterStart", busyO, 1);
        applyStimulus(1, 8'hFA, 1'b0, 0);
        applyStimulus(1, 8'h0C, 1'b0, 0);
        applyStimulus(3, 8'h00, 1'b0, 0);
        checkOutput("busyAfterStop", busyO, 0);
        drainFifo();
        checkPulses();

        // Repeated START with a NACKed second byte.
        applyStimulus(0, 8'h00, 1'b0, 0);
        applyStimulus(1, 8'hFA, 1'b0, 0);
        applyStimulus(0, 8'h00, 1'b0, 0);
        checkOutput("busyAcrossRestart", busyO, 1);
        applyStimulus(1, 8'h15, 1'b1, 0);
        applyStimulus(3, 8'h00, 1'b0, 0);
        drainFifo();
        checkPulses();

        // SDA glitch shorter than the filter, then a pulse just long enough.
        sdaIn = 1'b0; repeat (2) @(negedge clk); sdaIn = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("glitchCount", countO, 0);
        checkPulses();
        sdaIn = 1'b0; repeat (5) @(negedge clk); sdaIn = 1'b1;
        repeat (20) @(negedge clk);
        expStart++; expStop++;
        modelPush(11'h200); modelPush(11'h600);
        drainFifo();
        checkPulses();

        // STOP after three data bits.
        applyStimulus(0, 8'h00, 1'b0, 0);
        drainFifo();
        applyStimulus(2, 8'hA0, 1'b0, 3);
        applyStimulus(3, 8'h00, 1'b0, 0);
        drainFifo();
        checkPulses();

        // Overflow: ten records with no reads, then clear and a pop coinciding with a push.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 8'h00, 1'b0, 0);
            applyStimulus(3, 8'h00, 1'b0, 0);
        end
        checkOutput("fullCount", countO, expQ.size());
        checkOutput("ovfSet", ovfO, expOvf);
        ovfClr = 1'b1; @(negedge clk); ovfClr = 1'b0;
        expOvf = 0;
        @(negedge clk);
        checkOutput("ovfCleared", ovfO, 0);
        sdaIn = 1'b0;
        repeat (2 + FILT_LEN) @(negedge clk);
        rdEn = 1'b1; @(negedge clk); rdEn = 1'b0;
        void'(expQ.pop_front());
        expQ.push_back(11'h200);
        expStart++; mBusy = 1;
        checkOutput("pushPopCount", countO, expQ.size());
        checkOutput("pushPopOvf", ovfO, 0);
        waitQ(); sclIn = 1'b0; waitQ();
        drainFifo();
        applyStimulus(3, 8'h00, 1'b0, 0);
        drainFifo();
        checkPulses();

        // SCL held low after START.
        applyStimulus(0, 8'h00, 1'b0, 0);
        drainFifo();
        repeat (150) @(negedge clk);
`ifdef I2C_MON_TIMEOUT_EN
        checkOutput("timeoutPulses", obsTimeout, 1);
        checkOutput("busyAfterTimeout", busyO, 0);
`else
        checkOutput("timeoutPulses", obsTimeout, 0);
        checkOutput("busyWithoutTimeout", busyO, 1);
`endif
        applyStimulus(3, 8'h00, 1'b0, 0);
        drainFifo();
        checkPulses();

        // Random mix of transactions.
        for (int n = 0; n < 40; n++) begin
            if (mPartial) op = ($urandom_range(0, 1) == 0) ? 0 : 3;
            else if (!mBusy) op = 0;
            else begin
                r = $urandom_range(0, 9);
                op = (r < 5) ? 1 : (r == 5) ? 2 : (r < 8) ? 0 : 3;
            end
            applyStimulus(op, 8'($urandom), 1'($urandom), $urandom_range(1, 7));
            checkOutput("busyRandom", busyO, mBusy);
            drainFifo();
        end
        if (mBusy) begin
            applyStimulus(3, 8'h00, 1'b0, 0);
            drainFifo();
        end
        checkPulses();
        checkOutput("protoErrAlignment", perrStray, 0);

        // Reset in the middle of a byte with a record pending.
        applyStimulus(0, 8'h00, 1'b0, 0);
        applyStimulus(2, 8'h55, 1'b0, 3);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midByteReset", allOutputs(), 0);
        sclIn = 1'b1; sdaIn = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        expQ.delete(); mBusy = 0; mPartial = 0; expOvf = 0;
        repeat (20) @(negedge clk);
        drainFifo();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
